// File: rtl/cachewbbuf_if.sv
// Victim-capture, bus-beat and snoop signals of the dirty-line writeback buffer.
// master = cache controller / bus side, slave = the buffer itself.
interface cachewbbuf_if #(
  parameter int PALEN   = 32,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
);
  logic               EvictReq;
  logic               EvictDirty;
  logic [PALEN-1:0]   EvictAdr;
  logic [LINELEN-1:0] EvictLine;
  logic               BufFree;
  logic               WBPending;
  logic               WBValid;
  logic               WBReady;
  logic [PALEN-1:0]   WBAdr;
  logic [BEATLEN-1:0] WBData;
  logic               WBLast;
  logic [PALEN-1:0]   SnoopAdr;
  logic               SnoopHit;

  modport master (
    output EvictReq, EvictDirty, EvictAdr, EvictLine, WBReady, SnoopAdr,
    input  BufFree, WBPending, WBValid, WBAdr, WBData, WBLast, SnoopHit
  );

  modport slave (
    input  EvictReq, EvictDirty, EvictAdr, EvictLine, WBReady, SnoopAdr,
    output BufFree, WBPending, WBValid, WBAdr, WBData, WBLast, SnoopHit
  );
endinterface

// File: rtl/cachewbbuf.sv
// Single-entry dirty-victim writeback buffer: captures a line in one cycle, drains it as bus beats.
// Optional snoop comparator enabled by defining CACHEWBBUF_SNOOP_EN.
module cachewbbuf #(
  parameter int PALEN   = 32,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
) (
  input logic        clk,
  input logic        reset,
  cachewbbuf_if.slave bus
);
  localparam int NUMBEATS   = LINELEN / BEATLEN;
  localparam int BEATCNTLEN = $clog2(NUMBEATS);
  localparam int OFFSETLEN  = $clog2(LINELEN / 8);
  localparam int BEATSHIFT  = $clog2(BEATLEN / 8);
  localparam logic [BEATCNTLEN-1:0] LASTBEAT = BEATCNTLEN'(NUMBEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [BEATCNTLEN-1:0]  beat_reg, beat_next;
  logic [PALEN-1:0]       base_reg, base_next;
  logic [LINELEN-1:0]     line_reg, line_next;
  logic                   accept;
  logic                   is_last;
  logic [BEATLEN-1:0]     beat_slice [NUMBEATS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      base_reg  <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      base_reg  <= base_next;
      line_reg  <= line_next;
    end
  end

  assign accept  = bus.EvictReq & (state_reg == IDLE);
  assign is_last = (beat_reg == LASTBEAT);

  // Clean victims are acknowledged but never captured; a request while busy is ignored.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    base_next  = base_reg;
    line_next  = line_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept && bus.EvictDirty) begin
          base_next  = {bus.EvictAdr[PALEN-1:OFFSETLEN], {OFFSETLEN{1'b0}}};
          line_next  = bus.EvictLine;
          beat_next  = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.WBReady) begin
          if (is_last) begin
            state_next = IDLE;
          end else begin
            beat_next = beat_reg + BEATCNTLEN'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUMBEATS; gi++) begin : g_slice
      assign beat_slice[gi] = line_reg[gi*BEATLEN +: BEATLEN];
    end
  endgenerate

  // Beat outputs come straight from registers, so they hold during backpressure.
  assign bus.BufFree   = (state_reg == IDLE);
  assign bus.WBPending = (state_reg == DRAIN);
  assign bus.WBValid   = (state_reg == DRAIN);
  assign bus.WBLast    = (state_reg == DRAIN) & is_last;
  assign bus.WBData    = beat_slice[beat_reg];
  assign bus.WBAdr     = base_reg + (PALEN'(beat_reg) << BEATSHIFT);

`ifdef CACHEWBBUF_SNOOP_EN
  logic unused_offsets;
  assign unused_offsets = ^{bus.EvictAdr[OFFSETLEN-1:0], bus.SnoopAdr[OFFSETLEN-1:0]};
  assign bus.SnoopHit   = (state_reg == DRAIN) &
                          (bus.SnoopAdr[PALEN-1:OFFSETLEN] == base_reg[PALEN-1:OFFSETLEN]);
`else
  logic unused_offsets;
  assign unused_offsets = ^{bus.EvictAdr[OFFSETLEN-1:0], bus.SnoopAdr};
  assign bus.SnoopHit   = 1'b0;
`endif

endmodule

// File: tb/tb_cachewbbuf.sv
// Directed and random checks of cachewbbuf against a queue-of-expected-beats model.
module tb_cachewbbuf;
  localparam int PALEN   = 32;
  localparam int LINELEN = 256;
  localparam int BEATLEN = 64;
  localparam int NB      = LINELEN / BEATLEN;
`ifdef CACHEWBBUF_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cachewbbuf_if #(.PALEN(PALEN), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) bus ();
  cachewbbuf #(.PALEN(PALEN), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] adr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_base = '0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_snoop();
    if (!SNOOP || q.size() == 0) return 1'b0;
    return bus.SnoopAdr[31:5] == m_base[31:5];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".BufFree"}, bus.BufFree, q.size() == 0);
    chk({tag, ".WBValid"}, bus.WBValid, q.size() != 0);
    chk({tag, ".WBPending"}, bus.WBPending, q.size() != 0);
    chk({tag, ".SnoopHit"}, bus.SnoopHit, exp_snoop());
    if (q.size() != 0) begin
      chk({tag, ".WBAdr"}, bus.WBAdr, q[0].adr);
      chk({tag, ".WBData"}, bus.WBData, q[0].data);
      chk({tag, ".WBLast"}, bus.WBLast, q[0].last);
    end
  endtask

  // Advance the model on the inputs present now, clock once, then compare on the falling edge.
  task automatic tick(input string tag);
    logic acc, pop;
    acc = (q.size() == 0) && bus.EvictReq && bus.EvictDirty;
    pop = (q.size() != 0) && bus.WBReady;
    if (acc) begin
      m_base = {bus.EvictAdr[31:5], 5'b0};
      for (int b = 0; b < NB; b++)
        q.push_back('{m_base + 32'(b * 8), bus.EvictLine[b*64 +: 64], b == NB - 1});
    end else if (pop) begin
      void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic snoop_chk(input string tag, input logic [31:0] adr, input logic exp);
    bus.SnoopAdr = adr;
    #1;
    chk(tag, bus.SnoopHit, exp);
  endtask

  task automatic evict(input logic dirty, input logic [31:0] adr, input logic [255:0] line);
    bus.EvictReq   = 1'b1;
    bus.EvictDirty = dirty;
    bus.EvictAdr   = adr;
    bus.EvictLine  = line;
    tick("accept");
    bus.EvictReq  = 1'b0;
    bus.EvictLine = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [255:0] line;
    logic [31:0]  stall_adr;
    logic [63:0]  stall_data;
    logic [3:0]   nib;
    int           cyc;
    int           stalls;

    bus.EvictReq   = 1'b0;
    bus.EvictDirty = 1'b0;
    bus.EvictAdr   = '0;
    bus.EvictLine  = '0;
    bus.WBReady    = 1'b1;
    bus.SnoopAdr   = '0;

    // Reset values while held in reset.
    @(negedge clk);
    @(negedge clk);
    chk("rst.BufFree", bus.BufFree, 1'b1);
    chk("rst.WBValid", bus.WBValid, 1'b0);
    chk("rst.WBPending", bus.WBPending, 1'b0);
    chk("rst.SnoopHit", bus.SnoopHit, 1'b0);
    chk("rst.WBLast", bus.WBLast, 1'b0);
    chk("rst.WBAdr", bus.WBAdr, 32'h0);
    chk("rst.WBData", bus.WBData, 64'h0);
    reset = 1'b1;
    tick("post_rst");

    // Dirty evict of the reference line, full-speed drain.
    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    evict(1'b1, 32'h8000_0047, line);
    for (int k = 0; k < NB; k++) begin
      nib = 4'(k + 1);
      chk("dirty.adr", bus.WBAdr, 32'h8000_0040 + 32'(k * 8));
      chk("dirty.data", bus.WBData, {16{nib}});
      chk("dirty.last", bus.WBLast, k == NB - 1);
      if (k == 1) begin
        snoop_chk("snoop.5C", 32'h8000_005C, SNOOP);
        snoop_chk("snoop.60", 32'h8000_0060, 1'b0);
      end
      tick("dirty");
    end
    chk("dirty.cyc5.BufFree", bus.BufFree, 1'b1);
    chk("dirty.cyc5.WBValid", bus.WBValid, 1'b0);
    snoop_chk("snoop.after", 32'h8000_0040, 1'b0);

    // Clean evict is dropped.
    evict(1'b0, 32'h9000_0000, {8{$urandom}});
    chk("clean.WBValid", bus.WBValid, 1'b0);
    chk("clean.BufFree", bus.BufFree, 1'b1);
    tick("clean");

    // Backpressure on beat index 1 for three cycles.
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    evict(1'b1, 32'h1234_5600, line);
    cyc = 0;
    stalls = 0;
    while (bus.WBValid && cyc < 20) begin
      cyc++;
      if (q.size() == NB - 1 && stalls < 3) begin
        if (stalls == 0) begin
          stall_adr  = bus.WBAdr;
          stall_data = bus.WBData;
        end else begin
          chk("stall.adr", bus.WBAdr, stall_adr);
          chk("stall.data", bus.WBData, stall_data);
        end
        stalls++;
        bus.WBReady = 1'b0;
      end else begin
        bus.WBReady = 1'b1;
      end
      tick("stall");
    end
    bus.WBReady = 1'b1;
    chk("stall.cycles", cyc, 7);
    chk("stall.adr_const", stall_adr, 32'h1234_5608);

    // Asynchronous reset mid-drain, after beat 0 completed.
    evict(1'b1, 32'h4000_01E0, line);
    tick("pre_rst");
    #2 reset = 1'b0;
    #1;
    chk("arst.WBValid", bus.WBValid, 1'b0);
    chk("arst.WBPending", bus.WBPending, 1'b0);
    chk("arst.BufFree", bus.BufFree, 1'b1);
    chk("arst.WBAdr", bus.WBAdr, 32'h0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    evict(1'b1, 32'h5000_0020, line);
    chk("arst.new.adr", bus.WBAdr, 32'h5000_0020);
    chk("arst.new.data", bus.WBData, line[63:0]);
    for (int k = 0; k < NB; k++) tick("arst.drain");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.EvictReq   = ($urandom_range(0, 2) == 0);
      bus.EvictDirty = ($urandom_range(0, 3) != 0);
      bus.EvictAdr   = $urandom;
      bus.EvictLine  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.WBReady    = ($urandom_range(0, 3) != 0);
      bus.SnoopAdr   = $urandom_range(0, 1) ? (m_base | 32'($urandom_range(0, 31))) : $urandom;
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
